// File: rtl/elevator_scan_ctrl.sv
// Single-car SCAN elevator controller: pending-request bitmap, timed floor-to-floor travel,
// timed door dwell with obstruction/overload hold, and an emergency stop that freezes motion.
module elevator_scan_ctrl #(
    parameter int unsigned NUM_FLOORS    = 8,
    parameter int unsigned FLOOR_W       = $clog2(NUM_FLOORS),
    parameter int unsigned TRAVEL_CYCLES = 4,
    parameter int unsigned DOOR_CYCLES   = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_req_valid,
    input  logic [FLOOR_W-1:0]    i_req_floor,
    input  logic                  i_estop,
    input  logic                  i_ir_blocked,
    input  logic                  i_overload,
    output logic [FLOOR_W-1:0]    o_current_floor,
    output logic                  o_dir_up,
    output logic                  o_moving,
    output logic                  o_door_open,
    output logic [NUM_FLOORS-1:0] o_pending,
    output logic                  o_overload_warn,
    output logic                  o_estop_active
);

    localparam int unsigned TCNT_W = $clog2(TRAVEL_CYCLES + 1);
    localparam int unsigned DCNT_W = $clog2(DOOR_CYCLES + 1);

    localparam logic [TCNT_W-1:0]  TCNT_LAST = TCNT_W'(TRAVEL_CYCLES - 1);
    localparam logic [DCNT_W-1:0]  DCNT_LOAD = DCNT_W'(DOOR_CYCLES);
    localparam logic [FLOOR_W-1:0] TOP_FLOOR = FLOOR_W'(NUM_FLOORS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MOVE,
        S_DOOR,
        S_ESTOP
    } state_t;

    state_t                r_state;
    logic [FLOOR_W-1:0]    r_floor;
    logic                  r_dir_up;
    logic [TCNT_W-1:0]     r_tcnt;
    logic [DCNT_W-1:0]     r_dcnt;
    logic [NUM_FLOORS-1:0] r_pending;
    logic                  r_door_open;
    logic                  r_moving;
    logic                  r_overload_warn;
    logic                  r_estop_active;

    state_t                w_state_nxt;
    logic [FLOOR_W-1:0]    w_floor_nxt;
    logic                  w_dir_nxt;
    logic [TCNT_W-1:0]     w_tcnt_nxt;
    logic [DCNT_W-1:0]     w_dcnt_nxt;
    logic                  w_door_nxt;
    logic [NUM_FLOORS-1:0] w_clr;
    logic [NUM_FLOORS-1:0] w_set;
    logic [NUM_FLOORS-1:0] w_pending_nxt;
    logic                  w_req_in_range;
    logic                  w_req_cur;
    logic                  w_req_rec;
    logic                  w_at_end;
    logic [FLOOR_W-1:0]    w_step_floor;

    function automatic logic f_at(input logic [NUM_FLOORS-1:0] pend,
                                  input logic [FLOOR_W-1:0]    fl);
        logic hit;
        hit = 1'b0;
        for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
            if (FLOOR_W'(i) == fl) hit = pend[i];
        end
        return hit;
    endfunction

    function automatic logic f_above(input logic [NUM_FLOORS-1:0] pend,
                                     input logic [FLOOR_W-1:0]    fl);
        logic hit;
        hit = 1'b0;
        for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
            if (FLOOR_W'(i) > fl) hit = hit | pend[i];
        end
        return hit;
    endfunction

    function automatic logic f_below(input logic [NUM_FLOORS-1:0] pend,
                                     input logic [FLOOR_W-1:0]    fl);
        logic hit;
        hit = 1'b0;
        for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
            if (FLOOR_W'(i) < fl) hit = hit | pend[i];
        end
        return hit;
    endfunction

    function automatic logic [NUM_FLOORS-1:0] f_onehot(input logic [FLOOR_W-1:0] fl);
        logic [NUM_FLOORS-1:0] v;
        v = '0;
        for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
            v[i] = (FLOOR_W'(i) == fl);
        end
        return v;
    endfunction

    // Request capture; a hall call for the floor whose door is open only extends the dwell.
    assign w_req_in_range = (32'(i_req_floor) < NUM_FLOORS);
    assign w_req_cur      = i_req_valid && w_req_in_range && (i_req_floor == r_floor);
    assign w_req_rec      = i_req_valid && w_req_in_range &&
                            !((r_state == S_DOOR) && (i_req_floor == r_floor));
    assign w_set          = w_req_rec ? f_onehot(i_req_floor) : '0;
    assign w_pending_nxt  = (r_pending | w_set) & ~w_clr;

    assign w_at_end     = r_dir_up ? (r_floor == TOP_FLOOR) : (r_floor == '0);
    assign w_step_floor = r_dir_up ? (r_floor + FLOOR_W'(1)) : (r_floor - FLOOR_W'(1));

    // Next-state and datapath decode; all scheduling decisions use the registered bitmap.
    always_comb begin
        w_state_nxt = r_state;
        w_floor_nxt = r_floor;
        w_dir_nxt   = r_dir_up;
        w_tcnt_nxt  = r_tcnt;
        w_dcnt_nxt  = r_dcnt;
        w_door_nxt  = r_door_open;
        w_clr       = '0;

        if (i_estop) begin
            w_state_nxt = S_ESTOP;
            w_tcnt_nxt  = '0;
            if (r_state == S_MOVE) begin
                w_door_nxt = 1'b0;
            end else if (r_state != S_ESTOP) begin
                w_door_nxt = 1'b1;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_door_nxt = 1'b0;
                    w_tcnt_nxt = '0;
                    if (f_at(r_pending, r_floor)) begin
                        w_state_nxt = S_DOOR;
                    end else if (r_dir_up ? f_above(r_pending, r_floor)
                                          : f_below(r_pending, r_floor)) begin
                        w_state_nxt = S_MOVE;
                    end else if (r_dir_up ? f_below(r_pending, r_floor)
                                          : f_above(r_pending, r_floor)) begin
                        w_dir_nxt   = ~r_dir_up;
                        w_state_nxt = S_MOVE;
                    end
                end
                S_MOVE: begin
                    if (r_tcnt == TCNT_LAST) begin
                        w_tcnt_nxt = '0;
                        if (w_at_end) begin
                            w_state_nxt = S_IDLE;
                        end else begin
                            w_floor_nxt = w_step_floor;
                            if (f_at(r_pending, w_step_floor)) begin
                                w_state_nxt = S_DOOR;
                            end else if (r_dir_up ? f_above(r_pending, w_step_floor)
                                                  : f_below(r_pending, w_step_floor)) begin
                                w_state_nxt = S_MOVE;
                            end else begin
                                w_state_nxt = S_IDLE;
                            end
                        end
                    end else begin
                        w_tcnt_nxt = r_tcnt + TCNT_W'(1);
                    end
                end
                S_DOOR: begin
                    if (i_ir_blocked || i_overload || w_req_cur) begin
                        w_dcnt_nxt = DCNT_LOAD;
                    end else if (r_dcnt <= DCNT_W'(1)) begin
                        w_dcnt_nxt  = '0;
                        w_door_nxt  = 1'b0;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_dcnt_nxt = r_dcnt - DCNT_W'(1);
                    end
                end
                S_ESTOP: begin
                    w_tcnt_nxt  = '0;
                    w_state_nxt = r_door_open ? S_DOOR : S_IDLE;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end

        // Any fresh entry into DOOR opens the door, arms the dwell and serves the floor.
        if ((w_state_nxt == S_DOOR) && (r_state != S_DOOR)) begin
            w_door_nxt = 1'b1;
            w_dcnt_nxt = DCNT_LOAD;
            w_clr      = f_onehot(w_floor_nxt);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= S_IDLE;
            r_floor         <= '0;
            r_dir_up        <= 1'b1;
            r_tcnt          <= '0;
            r_dcnt          <= '0;
            r_pending       <= '0;
            r_door_open     <= 1'b0;
            r_moving        <= 1'b0;
            r_overload_warn <= 1'b0;
            r_estop_active  <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_floor         <= w_floor_nxt;
            r_dir_up        <= w_dir_nxt;
            r_tcnt          <= w_tcnt_nxt;
            r_dcnt          <= w_dcnt_nxt;
            r_pending       <= w_pending_nxt;
            r_door_open     <= w_door_nxt;
            r_moving        <= (w_state_nxt == S_MOVE);
            r_overload_warn <= i_overload && (w_state_nxt == S_DOOR);
            r_estop_active  <= (w_state_nxt == S_ESTOP);
        end
    end

    assign o_current_floor = r_floor;
    assign o_dir_up        = r_dir_up;
    assign o_moving        = r_moving;
    assign o_door_open     = r_door_open;
    assign o_pending       = r_pending;
    assign o_overload_warn = r_overload_warn;
    assign o_estop_active  = r_estop_active;

endmodule
